// File: rtl/alta_bram_pkg.sv
// alta_bram_pkg: shared definitions for the alta_bram port-A arbiter.
//   AW_DEFAULT / DW_DEFAULT : default address / data widths of the alta_bram port A.
//   client_e                : requester id carried through the read-latency pipeline.
//   rd_entry_t              : one read-latency pipeline slot {valid, id}.
package alta_bram_pkg;

  localparam int unsigned AW_DEFAULT = 12;
  localparam int unsigned DW_DEFAULT = 8;

  typedef enum logic {
    CLIENT_A = 1'b0,
    CLIENT_B = 1'b1
  } client_e;

  typedef struct packed {
    logic    valid;
    client_e id;
  } rd_entry_t;

endpackage

// File: rtl/alta_bram_rdpipe.sv
// alta_bram_rdpipe: RD_LATENCY-deep shift register of read tags {valid, id}.
// A tag pushed at the grant-cycle edge appears on the outputs after RD_LATENCY edges,
// which is exactly when the BRAM presents the matching DataOutA.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (clears all slots)
//   i_push_valid   : a read transfer happens this cycle
//   i_push_id      : id of the client issuing that read
//   o_ret_valid    : retiring slot holds a read whose data is on bram_dout now
//   o_ret_id       : id of that read's client
module alta_bram_rdpipe
  import alta_bram_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push_valid,
  input  logic i_push_id,
  output logic o_ret_valid,
  output logic o_ret_id
);

  rd_entry_t                  w_push;
  rd_entry_t [RD_LATENCY-1:0] r_stage;

  always_comb begin
    w_push       = '0;
    w_push.valid = i_push_valid;
    w_push.id    = client_e'(i_push_id);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= w_push;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_ret_valid = r_stage[RD_LATENCY-1].valid;
  assign o_ret_id    = r_stage[RD_LATENCY-1].id;

endmodule

// File: rtl/alta_bram_arbiter.sv
// alta_bram_arbiter: two-client round-robin arbiter for port A of one alta_bram.
// Grants are combinational; a transfer happens on a clk edge where req & gnt.
// Read results are routed back to the issuing client through a latency-matched tag
// pipeline and a capture register (rvalid at grant + RD_LATENCY + 1 cycles).
// Ports:
//   clk, rst                       : clock (also BRAM Clk0), async active-high reset
//   a_req/a_we/a_addr/a_wdata      : client A request (1 = write, 0 = read)
//   a_gnt                          : client A accept (combinational)
//   a_rvalid/a_rdata               : client A read result pulse / held data
//   b_*                            : same set for client B
//   bram_addr/bram_din/bram_we     : to AddressA / DataInA / WeRenA
//   bram_clken                     : to ClkEn0, tied high
//   bram_dout                      : from DataOutA
// RD_LATENCY must be 1 or 2 and match the BRAM output-register setting.
module alta_bram_arbiter
  import alta_bram_pkg::*;
#(
  parameter int unsigned AW         = AW_DEFAULT,
  parameter int unsigned DW         = DW_DEFAULT,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,

  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,

  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_din,
  output logic          bram_we,
  output logic          bram_clken,
  input  logic [DW-1:0] bram_dout
);

  client_e       r_prio;
  logic [AW-1:0] r_last_addr;
  logic          r_a_rvalid;
  logic          r_b_rvalid;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;

  logic          w_a_gnt;
  logic          w_b_gnt;
  logic          w_xfer;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_din;
  logic          w_we;
  logic          w_push_valid;
  logic          w_push_id;
  logic          w_ret_valid;
  logic          w_ret_id;

  // Grants are forced low during reset so nothing can commit while rst is high.
  assign w_a_gnt = ~rst & a_req & (~b_req | (r_prio == CLIENT_A));
  assign w_b_gnt = ~rst & b_req & (~a_req | (r_prio == CLIENT_B));
  assign w_xfer  = w_a_gnt | w_b_gnt;

  always_comb begin
    w_addr = r_last_addr;
    w_din  = '0;
    w_we   = 1'b0;
    if (w_a_gnt) begin
      w_addr = a_addr;
      w_din  = a_wdata;
      w_we   = a_we;
    end else if (w_b_gnt) begin
      w_addr = b_addr;
      w_din  = b_wdata;
      w_we   = b_we;
    end
  end

  assign w_push_valid = (w_a_gnt & ~a_we) | (w_b_gnt & ~b_we);
  assign w_push_id    = w_b_gnt;

  alta_bram_rdpipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rdpipe (
    .clk          (clk),
    .rst          (rst),
    .i_push_valid (w_push_valid),
    .i_push_id    (w_push_id),
    .o_ret_valid  (w_ret_valid),
    .o_ret_id     (w_ret_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio      <= CLIENT_A;
      r_last_addr <= '0;
    end else if (w_xfer) begin
      // Priority passes to whichever client lost (or did not ask) this cycle.
      r_prio      <= w_a_gnt ? CLIENT_B : CLIENT_A;
      r_last_addr <= w_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= w_ret_valid & (w_ret_id == CLIENT_A);
      r_b_rvalid <= w_ret_valid & (w_ret_id == CLIENT_B);
      if (w_ret_valid && (w_ret_id == CLIENT_A)) r_a_rdata <= bram_dout;
      if (w_ret_valid && (w_ret_id == CLIENT_B)) r_b_rdata <= bram_dout;
    end
  end

  assign a_gnt      = w_a_gnt;
  assign b_gnt      = w_b_gnt;
  assign a_rvalid   = r_a_rvalid;
  assign b_rvalid   = r_b_rvalid;
  assign a_rdata    = r_a_rdata;
  assign b_rdata    = r_b_rdata;
  assign bram_addr  = w_addr;
  assign bram_din   = w_din;
  assign bram_we    = w_we;
  assign bram_clken = 1'b1;

endmodule

// File: tb/tb_alta_bram_arbiter.sv
// tb_alta_bram_arbiter: directed bench driving one RD_LATENCY=1 and one RD_LATENCY=2
// arbiter from the same stimulus, each attached to its own behavioural alta_bram.
// Unwritten BRAM locations read as addr[7:0] ^ 8'h5F (so 0x005 holds 0x5A).
module tb_alta_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_init;

  logic        a_req, a_we, b_req, b_we;
  logic [11:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;

  logic        a_gnt1, b_gnt1, a_rv1, b_rv1, we1, clken1;
  logic [7:0]  a_rd1, b_rd1, din1, dout1;
  logic [11:0] addr1;
  logic        a_gnt2, b_gnt2, a_rv2, b_rv2, we2, clken2;
  logic [7:0]  a_rd2, b_rd2, din2, dout2, q2;
  logic [11:0] addr2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alta_bram_arbiter #(.AW(12), .DW(8), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt1), .a_rvalid(a_rv1), .a_rdata(a_rd1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt1), .b_rvalid(b_rv1), .b_rdata(b_rd1),
    .bram_addr(addr1), .bram_din(din1), .bram_we(we1), .bram_clken(clken1),
    .bram_dout(dout1)
  );

  alta_bram_arbiter #(.AW(12), .DW(8), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt2), .a_rvalid(a_rv2), .a_rdata(a_rd2),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt2), .b_rvalid(b_rv2), .b_rdata(b_rd2),
    .bram_addr(addr2), .bram_din(din2), .bram_we(we2), .bram_clken(clken2),
    .bram_dout(dout2)
  );

  // Behavioural BRAMs: written flag + data per location, default pattern otherwise.
  logic [511:0] wr1, wr2;
  logic [7:0]   wd1 [512];
  logic [7:0]   wd2 [512];

  always @(posedge clk) begin
    if (mem_init) begin
      wr1 <= '0;
      wr2 <= '0;
    end else begin
      if (we1) begin
        wr1[addr1[8:0]] <= 1'b1;
        wd1[addr1[8:0]] <= din1;
      end
      if (we2) begin
        wr2[addr2[8:0]] <= 1'b1;
        wd2[addr2[8:0]] <= din2;
      end
    end
    dout1 <= wr1[addr1[8:0]] ? wd1[addr1[8:0]] : (addr1[7:0] ^ 8'h5F);
    q2    <= wr2[addr2[8:0]] ? wd2[addr2[8:0]] : (addr2[7:0] ^ 8'h5F);
    dout2 <= q2;
  end

  // Expected-return history: index 0 = this cycle's grant, i = grant i cycles ago.
  logic       hv  [4];
  logic       hid [4];
  logic [7:0] hd  [4];
  logic [7:0] ea1, eb1, ea2, eb2;
  logic [11:0] exp_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_expect();
    for (int i = 0; i < 4; i++) begin
      hv[i] = 1'b0; hid[i] = 1'b0; hd[i] = 8'h00;
    end
    ea1 = 8'h00; eb1 = 8'h00; ea2 = 8'h00; eb2 = 8'h00;
    exp_last = 12'h000;
  endtask

  task automatic check_returns();
    if (hv[2] && !hid[2]) ea1 = hd[2];
    if (hv[2] &&  hid[2]) eb1 = hd[2];
    if (hv[3] && !hid[3]) ea2 = hd[3];
    if (hv[3] &&  hid[3]) eb2 = hd[3];
    chk("l1_a_rvalid", a_rv1, hv[2] && !hid[2]);
    chk("l1_b_rvalid", b_rv1, hv[2] &&  hid[2]);
    chk("l1_a_rdata",  a_rd1, ea1);
    chk("l1_b_rdata",  b_rd1, eb1);
    chk("l2_a_rvalid", a_rv2, hv[3] && !hid[3]);
    chk("l2_b_rvalid", b_rv2, hv[3] &&  hid[3]);
    chk("l2_a_rdata",  a_rd2, ea2);
    chk("l2_b_rdata",  b_rd2, eb2);
  endtask

  // One bus cycle: check returns, drive requests, check grant and BRAM drive.
  task automatic cyc(input logic ar, input logic aw, input logic [11:0] aa, input logic [7:0] ad,
                     input logic br, input logic bw, input logic [11:0] ba, input logic [7:0] bd,
                     input logic ega, input logic egb, input logic [7:0] erd);
    logic [11:0] xa;
    logic [7:0]  xd;
    logic        xw;
    @(negedge clk);
    for (int i = 3; i > 0; i--) begin
      hv[i] = hv[i-1]; hid[i] = hid[i-1]; hd[i] = hd[i-1];
    end
    hv[0] = 1'b0; hid[0] = 1'b0; hd[0] = 8'h00;
    check_returns();
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    chk("a_gnt_l1", a_gnt1, ega);
    chk("b_gnt_l1", b_gnt1, egb);
    chk("a_gnt_l2", a_gnt2, ega);
    chk("b_gnt_l2", b_gnt2, egb);
    if (ega) begin
      xa = aa; xd = ad; xw = aw;
    end else if (egb) begin
      xa = ba; xd = bd; xw = bw;
    end else begin
      xa = exp_last; xd = 8'h00; xw = 1'b0;
    end
    chk("bram_addr_l1", addr1, xa);
    chk("bram_din_l1",  din1,  xd);
    chk("bram_we_l1",   we1,   xw);
    chk("bram_addr_l2", addr2, xa);
    chk("bram_clken",   {clken1, clken2}, 2'b11);
    if (ega || egb) exp_last = xa;
    hv[0]  = (ega && !aw) || (egb && !bw);
    hid[0] = egb;
    hd[0]  = erd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 12'h0, 8'h0, 0, 0, 12'h0, 8'h0, 0, 0, 8'h0);
  endtask

  // Asynchronous reset pulse inside the current cycle, clear of both clock edges.
  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_a_rvalid", {a_rv1, a_rv2}, 2'b00);
    chk("rst_b_rvalid", {b_rv1, b_rv2}, 2'b00);
    chk("rst_a_rdata",  {a_rd1, a_rd2}, 16'h0000);
    chk("rst_b_rdata",  {b_rd1, b_rd2}, 16'h0000);
    chk("rst_bram_addr", {addr1, addr2}, 24'h000000);
    a_req = 1'b1; a_we = 1'b1; b_req = 1'b1; b_we = 1'b1;
    #0.5;
    chk("rst_gnt", {a_gnt1, b_gnt1, a_gnt2, b_gnt2}, 4'b0000);
    chk("rst_bram_we", {we1, we2}, 2'b00);
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0;
    #1 rst = 1'b0;
    clear_expect();
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    clear_expect();

    // Reset values before any clock edge.
    #1;
    chk("init_rvalid", {a_rv1, b_rv1, a_rv2, b_rv2}, 4'b0000);
    chk("init_rdata_l1", {a_rd1, b_rd1}, 16'h0000);
    chk("init_rdata_l2", {a_rd2, b_rd2}, 16'h0000);
    chk("init_bram_addr", {addr1, addr2}, 24'h000000);
    chk("init_bram_we", {we1, we2}, 2'b00);
    chk("init_clken", {clken1, clken2}, 2'b11);
    a_req = 1'b1; b_req = 1'b1;
    #1;
    chk("init_gnt_in_rst", {a_gnt1, b_gnt1, a_gnt2, b_gnt2}, 4'b0000);
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Idle: nothing granted, no rvalid, address parked at 0.
    idle(20);

    // Single read by A of 0x005 (pattern value 0x5A).
    cyc(1, 0, 12'h005, 8'h00, 0, 0, 12'h000, 8'h00, 1, 0, 8'h5A);
    idle(4);

    // Reset after the solo read so contention starts with prio = A.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cyc(1, 0, 12'h020 + 12'(k), 8'h00, 1, 0, 12'h030 + 12'(k), 8'h00,
          (k % 2) == 0, (k % 2) == 1,
          ((k % 2) == 0) ? (8'h7F - 8'(k)) : (8'h6F - 8'(k)));
    end
    idle(4);

    // B writes 0xC3 to 0x1FF, A reads it back the next cycle.
    cyc(0, 0, 12'h000, 8'h00, 1, 1, 12'h1FF, 8'hC3, 0, 1, 8'h00);
    cyc(1, 0, 12'h1FF, 8'h00, 0, 0, 12'h000, 8'h00, 1, 0, 8'hC3);
    idle(4);

    // Two reads in flight then reset. With RD_LATENCY=1 the A read has already
    // retired when the reset lands; everything younger must vanish.
    cyc(1, 0, 12'h010, 8'h00, 0, 0, 12'h000, 8'h00, 1, 0, 8'h4F);
    cyc(0, 0, 12'h000, 8'h00, 1, 0, 12'h011, 8'h00, 0, 1, 8'h4E);
    idle(1);
    do_reset();
    idle(4);

    // First contended grant after reset goes to A, then B.
    cyc(1, 0, 12'h010, 8'h00, 1, 0, 12'h011, 8'h00, 1, 0, 8'h4F);
    cyc(0, 0, 12'h000, 8'h00, 1, 0, 12'h011, 8'h00, 0, 1, 8'h4E);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
